// File: rtl/output_arbiter_credit_if.sv
// output_arbiter_credit_if
//   Handshake bundle between one router output arbiter and its surroundings.
//   master : routing logic / input FIFOs / downstream credit return side
//   slave  : the arbiter itself
//   req[4:0]       per-input request for this output
//   valid[4:0]     per-input FIFO non-empty
//   tail[4:0]      per-input head flit is a tail flit
//   credit_in      one-cycle pulse, downstream freed one slot
//   sel[4:0]       registered one-hot crossbar select
//   grant[4:0]     per-input FIFO read enable (one-hot or zero)
//   valid_out      flit driven on the output link this cycle
//   credits[CW-1:0] current downstream credit count
//   credit_err     sticky credit overflow flag
//   Bit order: [0]=Local [1]=South [2]=West [3]=East [4]=North.
interface output_arbiter_credit_if #(
   parameter int unsigned CREDIT_MAX = 4
);
   localparam int unsigned CW = $clog2(CREDIT_MAX + 1);

   logic [4:0]    req;
   logic [4:0]    valid;
   logic [4:0]    tail;
   logic          credit_in;
   logic [4:0]    sel;
   logic [4:0]    grant;
   logic          valid_out;
   logic [CW-1:0] credits;
   logic          credit_err;

   modport master (
      output req, valid, tail, credit_in,
      input  sel, grant, valid_out, credits, credit_err
   );

   modport slave (
      input  req, valid, tail, credit_in,
      output sel, grant, valid_out, credits, credit_err
   );
endinterface

// File: rtl/output_arbiter_credit.sv
// output_arbiter_credit
//   Per-output-port packet arbiter with downstream credit counter.
//   Round-robin choice among five input FIFOs (L,S,W,E,N); once a head is
//   chosen the output stays locked to that input until its tail flit leaves.
//   One credit is spent per flit sent; credits return via credit_in.
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     bus    output_arbiter_credit_if slave modport (see interface header)
module output_arbiter_credit #(
   parameter int unsigned CREDIT_MAX = 4
) (
   input logic                      clk,
   input logic                      reset,
   output_arbiter_credit_if.slave   bus
);
   localparam int unsigned    CW        = $clog2(CREDIT_MAX + 1);
   localparam logic [CW-1:0]  CRED_FULL = CW'(CREDIT_MAX);
   localparam logic [CW-1:0]  CRED_ONE  = CW'(1);

   // Encoding keeps LOCK_x == input index + 1 so the locked input is state-1.
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOCK_L = 3'd1,
      LOCK_S = 3'd2,
      LOCK_W = 3'd3,
      LOCK_E = 3'd4,
      LOCK_N = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic [2:0]    rr_q, rr_d;
   logic [4:0]    sel_q, sel_d;
   logic [CW-1:0] credits_q, credits_d;
   logic          err_q, err_d;

   logic [2:0]    lock_idx;
   logic          locked;
   logic          transfer;
   logic [4:0]    grant_c;
   logic [2:0]    pick_idx;
   logic          pick_found;
   logic [3:0]    cand;

   assign locked   = (state_q != IDLE);
   assign lock_idx = state_q - 3'd1;
   assign transfer = locked && bus.valid[lock_idx] && (credits_q != '0);

   // Round-robin search: first requesting input at or after the pointer.
   always_comb begin
      pick_idx   = '0;
      pick_found = 1'b0;
      cand       = '0;
      for (int unsigned i = 0; i < 5; i++) begin
         cand = {1'b0, rr_q} + 4'(i);
         if (cand >= 4'd5) begin
            cand = cand - 4'd5;
         end
         if (!pick_found && bus.req[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand[2:0];
         end
      end
   end

   // Next state, select, pointer and grant.
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      rr_d    = rr_q;
      grant_c = '0;
      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d = state_t'(pick_idx + 3'd1);
               sel_d   = 5'b00001 << pick_idx;
            end
         end
         default: begin
            // req is deliberately ignored here: only the tail releases the lock.
            if (transfer) begin
               grant_c = sel_q;
               if (bus.tail[lock_idx]) begin
                  state_d = IDLE;
                  sel_d   = '0;
                  rr_d    = (lock_idx == 3'd4) ? 3'd0 : lock_idx + 3'd1;
               end
            end
         end
      endcase
   end

   // Credit counter: a spend and a return in the same cycle cancel out.
   always_comb begin
      credits_d = credits_q;
      err_d     = err_q;
      if (transfer && !bus.credit_in) begin
         credits_d = credits_q - CRED_ONE;
      end else if (bus.credit_in && !transfer) begin
         if (credits_q == CRED_FULL) begin
            err_d = 1'b1;
         end else begin
            credits_d = credits_q + CRED_ONE;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         sel_q     <= '0;
         rr_q      <= '0;
         credits_q <= CRED_FULL;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         sel_q     <= sel_d;
         rr_q      <= rr_d;
         credits_q <= credits_d;
         err_q     <= err_d;
      end
   end

   assign bus.sel        = sel_q;
   assign bus.grant      = grant_c;
   assign bus.valid_out  = transfer;
   assign bus.credits    = credits_q;
   assign bus.credit_err = err_q;
endmodule

// File: tb/tb_output_arbiter_credit.sv
// tb_output_arbiter_credit
//   Directed scenarios followed by a random phase; every cycle the outputs are
//   compared against a packet-level reference model (lock owner, rr pointer,
//   credit count, sticky error) kept as plain integers.
module tb_output_arbiter_credit;
   localparam int unsigned CREDIT_MAX = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   output_arbiter_credit_if #(.CREDIT_MAX(CREDIT_MAX)) bus ();

   output_arbiter_credit #(.CREDIT_MAX(CREDIT_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model state
   bit m_locked;
   int m_port;
   int m_rr;
   int m_credits;
   bit m_err;
   int grant_log[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_locked  = 1'b0;
      m_port    = 0;
      m_rr      = 0;
      m_credits = CREDIT_MAX;
      m_err     = 1'b0;
   endtask

   task automatic idle_inputs();
      bus.req       = '0;
      bus.valid     = '0;
      bus.tail      = '0;
      bus.credit_in = 1'b0;
   endtask

   // One clock cycle: compare outputs mid-cycle, advance the model, cross the edge.
   task automatic step();
      logic [4:0] e_sel;
      logic [4:0] e_grant;
      bit         xfer;
      @(negedge clk);
      e_sel   = m_locked ? 5'(1 << m_port) : 5'b0;
      xfer    = m_locked && bus.valid[m_port] && (m_credits > 0);
      e_grant = xfer ? e_sel : 5'b0;
      check("sel",        32'(bus.sel),        32'(e_sel));
      check("grant",      32'(bus.grant),      32'(e_grant));
      check("valid_out",  32'(bus.valid_out),  32'(xfer));
      check("credits",    32'(bus.credits),    32'(m_credits));
      check("credit_err", 32'(bus.credit_err), 32'(m_err));
      if (xfer) grant_log.push_back(m_port);
      if (!m_locked) begin
         for (int k = 0; k < 5; k++) begin
            int c;
            c = (m_rr + k) % 5;
            if (bus.req[c]) begin
               m_locked = 1'b1;
               m_port   = c;
               break;
            end
         end
      end else if (xfer && bus.tail[m_port]) begin
         m_locked = 1'b0;
         m_rr     = (m_port + 1) % 5;
      end
      if (xfer && !bus.credit_in) begin
         m_credits--;
      end else if (bus.credit_in && !xfer) begin
         if (m_credits == CREDIT_MAX) m_err = 1'b1;
         else m_credits++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic refill(input int n);
      idle_inputs();
      bus.credit_in = 1'b1;
      repeat (n) step();
      bus.credit_in = 1'b0;
   endtask

   initial begin
      logic [4:0] exp_order [6];
      idle_inputs();
      model_reset();
      #23 reset = 1'b1;
      @(posedge clk);
      #1;
      check("rst_sel",     32'(bus.sel),        32'd0);
      check("rst_credits", 32'(bus.credits),    32'(CREDIT_MAX));
      check("rst_err",     32'(bus.credit_err), 32'd0);

      // Async reset in the middle of an East packet
      bus.req   = 5'b01000;
      bus.valid = 5'b01000;
      step();
      step();
      #2 reset = 1'b0;
      #1;
      check("arst_sel",       32'(bus.sel),        32'd0);
      check("arst_grant",     32'(bus.grant),      32'd0);
      check("arst_valid_out", 32'(bus.valid_out),  32'd0);
      check("arst_credits",   32'(bus.credits),    32'(CREDIT_MAX));
      check("arst_err",       32'(bus.credit_err), 32'd0);
      idle_inputs();
      #1 reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;

      // Single 3-flit packet from West
      bus.req   = 5'b00100;
      bus.valid = 5'b00100;
      step();
      check("w_sel_n1", 32'(bus.sel), 32'b00100);
      bus.req = '0;
      step();
      step();
      bus.tail = 5'b00100;
      step();
      check("w_credits", 32'(bus.credits), 32'd1);
      check("w_idle",    32'(bus.sel),     32'd0);
      refill(3);

      // Single-flit North packet moves the pointer back to Local
      bus.req   = 5'b10000;
      bus.valid = 5'b10000;
      bus.tail  = 5'b10000;
      step();
      step();
      refill(1);

      // Round robin with all inputs requesting single-flit packets
      grant_log.delete();
      bus.req   = 5'b11111;
      bus.valid = 5'b11111;
      bus.tail  = 5'b11111;
      for (int i = 0; i < 12; i++) begin
         bus.credit_in = (i >= 2) && (i % 2 == 0);
         step();
      end
      exp_order = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd0};
      check("rr_count", 32'(grant_log.size()), 32'd6);
      for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
         check("rr_order", 32'(grant_log[i]), 32'(exp_order[i]));
      end
      refill(1);

      // Credit stall on a 6-flit North packet
      grant_log.delete();
      bus.req   = 5'b10000;
      bus.valid = 5'b10000;
      step();
      bus.req = '0;
      repeat (7) step();
      check("stall_credits", 32'(bus.credits),   32'd0);
      check("stall_sel",     32'(bus.sel),       32'b10000);
      check("stall_vout",    32'(bus.valid_out), 32'd0);
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      step();
      step();
      check("stall_grants", 32'(grant_log.size()), 32'd5);
      bus.tail      = 5'b10000;
      bus.credit_in = 1'b1;
      step();
      bus.credit_in = 1'b0;
      step();
      refill(4);

      // Simultaneous transfer and credit return, then overflow
      bus.req   = 5'b00100;
      bus.valid = 5'b00100;
      step();
      bus.credit_in = 1'b1;
      step();
      check("sim_credits", 32'(bus.credits),    32'(CREDIT_MAX));
      check("sim_err",     32'(bus.credit_err), 32'd0);
      bus.credit_in = 1'b0;
      bus.tail      = 5'b00100;
      step();
      refill(2);
      check("ovf_credits", 32'(bus.credits),    32'(CREDIT_MAX));
      check("ovf_err",     32'(bus.credit_err), 32'd1);

      // Lock integrity: South packet with gaps while North requests
      bus.req   = 5'b00010;
      bus.valid = 5'b00010;
      step();
      bus.req = 5'b10000;
      for (int i = 0; i < 5; i++) begin
         bus.valid = (i % 2 == 0) ? 5'b10010 : 5'b10000;
         bus.tail  = (i == 4) ? 5'b00010 : 5'b00000;
         step();
         if (i < 4) check("lock_sel", 32'(bus.sel), 32'b00010);
      end
      bus.tail = 5'b10000;
      step();
      check("next_n_sel", 32'(bus.sel), 32'b10000);
      step();
      refill(4);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         bus.req       = 5'($urandom);
         bus.valid     = 5'($urandom) | 5'($urandom);
         bus.tail      = 5'($urandom) & 5'($urandom);
         bus.credit_in = ($urandom_range(0, 2) == 0);
         step();
      end

      // Reset clears the sticky error
      #2 reset = 1'b0;
      #1;
      check("fin_err",     32'(bus.credit_err), 32'd0);
      check("fin_credits", 32'(bus.credits),    32'(CREDIT_MAX));
      check("fin_sel",     32'(bus.sel),        32'd0);
      idle_inputs();
      #1 reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
